// File: rtl/regfile_hw_mapped.sv
// 2-read/1-write CPU register file with per-register hardware mapping:
// plain, hardware-owned snapshot, and sticky (hw set / CPU W1C) registers.
module regfile_hw_mapped #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter logic [(1<<ADDR_WIDTH)-1:0] HW_RO_MASK  = 32'h0000_01CE,
    parameter logic [(1<<ADDR_WIDTH)-1:0] STICKY_MASK = 32'h0000_000C
) (
    input  logic                                      clock,
    input  logic                                      ctrl_reset_n,
    input  logic                                      ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]                     ctrl_writeReg,
    input  logic [ADDR_WIDTH-1:0]                     ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0]                     ctrl_readRegB,
    input  logic [DATA_WIDTH-1:0]                     data_writeReg,
    output logic [DATA_WIDTH-1:0]                     data_readRegA,
    output logic [DATA_WIDTH-1:0]                     data_readRegB,
    input  logic [(1<<ADDR_WIDTH)-1:0]                hw_in_valid,
    input  logic [(1<<ADDR_WIDTH)*DATA_WIDTH-1:0]     hw_in_data,
    output logic [(1<<ADDR_WIDTH)*DATA_WIDTH-1:0]     hw_regs_out,
    output logic [(1<<ADDR_WIDTH)-1:0]                cpu_write_strobe
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      strobe_q;
    logic [DEPTH-1:0]      strobe_d;

    // hw inputs of plain registers and reg 0 are intentionally ignored
    logic unused_hw;
    assign unused_hw = ^{hw_in_valid, hw_in_data};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i]   = regs_q[i];
            strobe_d[i] = 1'b0;
            if (i == 0) begin
                regs_d[i] = '0;
            end else if (STICKY_MASK[i]) begin
                if (ctrl_writeEnable && ctrl_writeReg == ADDR_WIDTH'(i)) begin
                    regs_d[i]   = regs_d[i] & ~data_writeReg;
                    strobe_d[i] = 1'b1;
                end
                if (hw_in_valid[i])
                    regs_d[i] = regs_d[i] | hw_in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (HW_RO_MASK[i]) begin
                if (hw_in_valid[i])
                    regs_d[i] = hw_in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                if (ctrl_writeEnable && ctrl_writeReg == ADDR_WIDTH'(i)) begin
                    regs_d[i]   = data_writeReg;
                    strobe_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            strobe_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= regs_d[i];
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        hw_regs_out = '0;
        for (int i = 0; i < DEPTH; i++)
            hw_regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign cpu_write_strobe = strobe_q;

    // only plain registers forward; hw-owned ones return the stored value
    logic fwd_a, fwd_b;
    assign fwd_a = ctrl_writeEnable && (ctrl_readRegA == ctrl_writeReg)
                   && !HW_RO_MASK[ctrl_readRegA];
    assign fwd_b = ctrl_writeEnable && (ctrl_readRegB == ctrl_writeReg)
                   && !HW_RO_MASK[ctrl_readRegB];

    always_comb begin
        data_readRegA = regs_q[ctrl_readRegA];
        if (ctrl_readRegA == '0)
            data_readRegA = '0;
        else if (fwd_a)
            data_readRegA = data_writeReg;
    end

    always_comb begin
        data_readRegB = regs_q[ctrl_readRegB];
        if (ctrl_readRegB == '0)
            data_readRegB = '0;
        else if (fwd_b)
            data_readRegB = data_writeReg;
    end

endmodule

// File: tb/tb_regfile_hw_mapped.sv
// Directed bench for regfile_hw_mapped: reset, forwarding, snapshot,
// sticky set/clear, set-vs-clear race and dual read.
module tb_regfile_hw_mapped;

    logic          clock = 1'b0;
    logic          ctrl_reset_n;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg;
    logic [4:0]    ctrl_readRegA;
    logic [4:0]    ctrl_readRegB;
    logic [31:0]   data_writeReg;
    logic [31:0]   data_readRegA;
    logic [31:0]   data_readRegB;
    logic [31:0]   hw_in_valid;
    logic [1023:0] hw_in_data;
    logic [1023:0] hw_regs_out;
    logic [31:0]   cpu_write_strobe;

    int n_chk  = 0;
    int n_pass = 0;

    regfile_hw_mapped dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .hw_in_valid      (hw_in_valid),
        .hw_in_data       (hw_in_data),
        .hw_regs_out      (hw_regs_out),
        .cpu_write_strobe (cpu_write_strobe)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic hw_set(input int r, input logic [31:0] v);
        hw_in_valid[r] = 1'b1;
        hw_in_data[r*32 +: 32] = v;
    endtask

    task automatic idle();
        ctrl_writeEnable = 1'b0;
        hw_in_valid      = '0;
        hw_in_data       = '0;
    endtask

    initial begin
        ctrl_reset_n     = 1'b0;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd10;
        data_writeReg    = 32'hDEAD_BEEF;
        ctrl_readRegA    = 5'd10;
        ctrl_readRegB    = 5'd0;
        hw_in_valid      = '0;
        hw_in_data       = '0;
        step();
        step();
        chk("rst_image", {31'd0, |hw_regs_out}, 32'd0);
        chk("rst_strobe", cpu_write_strobe, 32'd0);
        ctrl_reset_n = 1'b1;
        idle();
        #1;
        chk("rst_reg10", data_readRegA, 32'd0);
        step();
        chk("rst_nostrobe", cpu_write_strobe, 32'd0);

        // plain write with same-cycle forward
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h1234_5678;
        ctrl_readRegA    = 5'd9;
        #1;
        chk("fwd_a9", data_readRegA, 32'h1234_5678);
        step();
        idle();
        chk("img9", hw_regs_out[9*32 +: 32], 32'h1234_5678);
        chk("strobe9_on", {31'd0, cpu_write_strobe[9]}, 32'd1);
        // hw input on a plain register is ignored
        hw_set(9, 32'hFFFF_0000);
        step();
        idle();
        chk("strobe9_off", {31'd0, cpu_write_strobe[9]}, 32'd0);
        chk("plain_hw_ign", data_readRegA, 32'h1234_5678);

        // writes to reg 0 are dropped
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'h5555_5555;
        ctrl_readRegA    = 5'd0;
        hw_set(0, 32'h7);
        #1;
        chk("r0_fwd", data_readRegA, 32'd0);
        step();
        idle();
        chk("r0_read", data_readRegA, 32'd0);
        chk("r0_strobe", {31'd0, cpu_write_strobe[0]}, 32'd0);

        // snapshot register 6
        hw_set(6, 32'd500);
        step();
        idle();
        hw_in_data[6*32 +: 32] = 32'd7;
        step();
        ctrl_readRegA = 5'd6;
        #1;
        chk("snap_hold", data_readRegA, 32'd500);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd6;
        data_writeReg    = 32'd99;
        #1;
        chk("snap_nofwd", data_readRegA, 32'd500);
        step();
        idle();
        chk("snap_ro", data_readRegA, 32'd500);
        chk("snap_strobe", {31'd0, cpu_write_strobe[6]}, 32'd0);

        // sticky register 2
        hw_set(2, 32'h1);
        step();
        idle();
        hw_set(2, 32'h4);
        step();
        idle();
        ctrl_readRegB = 5'd2;
        #1;
        chk("sticky_or", data_readRegB, 32'h5);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd2;
        data_writeReg    = 32'h1;
        #1;
        chk("sticky_nofwd", data_readRegB, 32'h5);
        step();
        idle();
        chk("sticky_w1c", data_readRegB, 32'h4);
        chk("sticky_strobe", {31'd0, cpu_write_strobe[2]}, 32'd1);

        // set beats a same-cycle clear
        hw_set(3, 32'hA);
        step();
        idle();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'hF;
        hw_set(3, 32'h2);
        step();
        idle();
        chk("race_img3", hw_regs_out[3*32 +: 32], 32'h2);
        chk("race_strobe", {31'd0, cpu_write_strobe[3]}, 32'd1);

        // dual read of the same register during a write
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd4;
        data_writeReg    = 32'hA5;
        ctrl_readRegA    = 5'd4;
        ctrl_readRegB    = 5'd4;
        #1;
        chk("dual_a", data_readRegA, 32'hA5);
        chk("dual_b", data_readRegB, 32'hA5);
        step();
        idle();
        chk("dual_img4", hw_regs_out[4*32 +: 32], 32'hA5);

        // asynchronous reset mid-run
        ctrl_readRegA = 5'd9;
        #2;
        chk("pre_rst9", data_readRegA, 32'h1234_5678);
        ctrl_reset_n = 1'b0;
        #1;
        chk("arst_reg9", data_readRegA, 32'd0);
        chk("arst_image", {31'd0, |hw_regs_out}, 32'd0);
        chk("arst_strobe", cpu_write_strobe, 32'd0);
        step();
        ctrl_reset_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
